corner_state_writer: RTL
========================

Name: corner_state_writer

Overview:
- Other end of the corner-index path. The corner lookup reads 3-bit corner sticker fields out of cubestate. This block builds those fields.
- It accepts sticker colours one corner at a time, in learning order (corner_num 0..23), over a valid/ready handshake. It packs each colour into the 72-bit corner cubestate and checks colour legality and colour counts.
- It sits between the colour-sensing front end and the solver, and emits corner_num so the lookup can run in lockstep.

Parameters:
- NUM_CORNERS, 24, number of corner stickers learned per scan.
- COLOUR_W, 3, bits per sticker colour field.
- NUM_COLOURS, 6, legal colour codes are 0..NUM_COLOURS-1.
- MAX_PER_COLOUR, 4, maximum corner stickers of any one colour.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a new scan from IDLE or ERROR.
- sticker_valid  in  1  the front end presents a colour.
- sticker_colour  in  3  colour code of the current corner sticker.
- sticker_ready  out  1  the block accepts a colour this cycle.
- corner_num  out  5  index of the next corner to be written (0..23).
- cubestate  out  72  packed corner colours; corner n occupies [71-3n : 69-3n].
- busy  out  1  high while in LOAD.
- done  out  1  one-cycle pulse after corner 23 is written.
- error  out  1  held high in ERROR.
- error_code  out  2  0 = none, 1 = illegal colour, 2 = colour over-count.

Behaviour:
- Reset (reset_n=0 at a clock edge), including mid-scan:
  - state=IDLE, cubestate=0, corner_num=0, all colour counters=0.
  - sticker_ready=0, busy=0, done=0, error=0, error_code=0.
- All outputs are registered.
- States: IDLE, LOAD, DONE, ERROR.
- IDLE:
  - sticker_ready=0; cubestate holds its last value.
  - start=1: clear cubestate, corner_num, all six 3-bit colour counters, error, error_code; next state LOAD.
- LOAD:
  - sticker_ready=1 and busy=1, from the first LOAD cycle.
  - A transfer occurs when sticker_valid & sticker_ready at a clock edge. No transfer means no state change; valid may stay high indefinitely.
  - On a transfer with colour c:
    - c >= NUM_COLOURS: no write, error=1, error_code=1, next state ERROR.
    - else if count[c] == MAX_PER_COLOUR: no write, error=1, error_code=2, next state ERROR.
    - else: write c into field [71-3n : 69-3n], where n = corner_num; count[c]++; corner_num++.
  - Transfer at corner_num == NUM_CORNERS-1:
    - The field is written and corner_num wraps to 0.
    - Next state DONE, so sticker_ready is low on the following cycle.
  - The illegal-colour check has priority over the over-count check.
  - start in LOAD is ignored.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, sticker_ready=0.
  - Then IDLE, with the full cubestate held.
  - start in DONE is ignored.
- ERROR:
  - sticker_ready=0, busy=0; error and error_code held.
  - cubestate holds the partial contents; corner_num holds the failing index.
  - start=1 behaves exactly as in IDLE and clears the error.
- Arithmetic:
  - Each count[c] is 3 bits and never exceeds 4.
  - corner_num is 5 bits and never exceeds 23.
  - Field placement is a constant-stride 3-bit write; no other bits of cubestate change on a transfer.
- Latency:
  - start to sticker_ready high: 1 cycle.
  - Last transfer to done pulse: 1 cycle.
  - Each transfer is reflected in cubestate and corner_num on the next cycle.

Test Plan:
- Reset, then start, then 24 transfers of colours (n mod 6) back to back:
  - done pulses one cycle after the 24th transfer.
  - cubestate[71:69]=0, [68:66]=1, [2:0]=5.
  - corner_num=0, error=0.
- Same stimulus, with sticker_valid gapped on odd cycles:
  - Identical final cubestate; corner_num advances only on transfer cycles.
- Corner 5 receives colour 7:
  - error=1, error_code=1, corner_num=5.
  - cubestate[56:54] stays 0; sticker_ready low from the next cycle.
- Five consecutive transfers of colour 2:
  - The fifth gives error_code=2 with corner_num=4; fields 0..3 are all 2.
- reset_n=0 asserted after 10 transfers:
  - Next cycle cubestate=0, corner_num=0, state IDLE.
  - start then yields a clean 24-corner scan.
- From ERROR, pulse start:
  - error and error_code clear, cubestate=0, sticker_ready=1 the next cycle.
  - start pulses in LOAD and DONE cause no change.

Source files
------------

// File: rtl/corner_state_writer_if.sv
// rtl/corner_state_writer_if.sv - sticker colour handshake between front end and corner writer
interface corner_state_writer_if #(
    parameter int COLOUR_W = 3
);
    logic                sticker_valid;
    logic [COLOUR_W-1:0] sticker_colour;
    logic                sticker_ready;

    modport master (
        output sticker_valid,
        output sticker_colour,
        input  sticker_ready
    );

    modport slave (
        input  sticker_valid,
        input  sticker_colour,
        output sticker_ready
    );
endinterface

// File: rtl/corner_state_writer.sv
// rtl/corner_state_writer.sv - packs learned corner sticker colours into the 72-bit corner cubestate
module corner_state_writer #(
    parameter int NUM_CORNERS    = 24,
    parameter int COLOUR_W       = 3,
    parameter int NUM_COLOURS    = 6,
    parameter int MAX_PER_COLOUR = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    corner_state_writer_if.slave            stk,
    output logic [4:0]                      corner_num,
    output logic [NUM_CORNERS*COLOUR_W-1:0] cubestate,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [1:0]                      error_code
);
    localparam int                  STATE_W     = NUM_CORNERS * COLOUR_W;
    localparam int                  LSB_W       = $clog2(STATE_W);
    localparam logic [COLOUR_W-1:0] LAST_COLOUR = COLOUR_W'(NUM_COLOURS - 1);
    localparam logic [2:0]          MAX_COUNT   = 3'(MAX_PER_COLOUR);
    localparam logic [4:0]          LAST_CORNER = 5'(NUM_CORNERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t     state;
    logic [2:0] count [NUM_COLOURS];

    logic [LSB_W-1:0] field_lsb;
    logic [2:0]       cur_count;
    logic             colour_illegal;
    logic             colour_full;
    logic             transfer;

    // Corner 0 lives in the top field, so the field base counts down as corner_num rises.
    always_comb begin
        field_lsb      = LSB_W'((NUM_CORNERS - 1 - int'(corner_num)) * COLOUR_W);
        colour_illegal = (stk.sticker_colour > LAST_COLOUR);
        cur_count      = '0;
        if (!colour_illegal) begin
            cur_count = count[stk.sticker_colour];
        end
        colour_full = (cur_count == MAX_COUNT);
        transfer    = stk.sticker_valid && stk.sticker_ready;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            cubestate         <= '0;
            corner_num        <= '0;
            stk.sticker_ready <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            error_code        <= 2'd0;
            for (int i = 0; i < NUM_COLOURS; i++) begin
                count[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_ERROR: begin
                    done <= 1'b0;
                    if (start) begin
                        state             <= S_LOAD;
                        cubestate         <= '0;
                        corner_num        <= '0;
                        stk.sticker_ready <= 1'b1;
                        busy              <= 1'b1;
                        error             <= 1'b0;
                        error_code        <= 2'd0;
                        for (int i = 0; i < NUM_COLOURS; i++) begin
                            count[i] <= '0;
                        end
                    end
                end

                S_LOAD: begin
                    if (transfer) begin
                        if (colour_illegal || colour_full) begin
                            state             <= S_ERROR;
                            stk.sticker_ready <= 1'b0;
                            busy              <= 1'b0;
                            error             <= 1'b1;
                            error_code        <= colour_illegal ? 2'd1 : 2'd2;
                        end else begin
                            cubestate[field_lsb +: COLOUR_W] <= stk.sticker_colour;
                            count[stk.sticker_colour]        <= cur_count + 3'd1;
                            if (corner_num == LAST_CORNER) begin
                                state             <= S_DONE;
                                corner_num        <= '0;
                                stk.sticker_ready <= 1'b0;
                                busy              <= 1'b0;
                                done              <= 1'b1;
                            end else begin
                                corner_num <= corner_num + 5'd1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state             <= S_IDLE;
                    stk.sticker_ready <= 1'b0;
                    busy              <= 1'b0;
                    done              <= 1'b0;
                end
            endcase
        end
    end
endmodule
